// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_pkg
// Description : Shared defaults and types for the scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_sb_pkg;

    // Default geometry of the integer register file
    localparam int XLEN_DEFAULT = 64;
    localparam int NREG_DEFAULT = 32;

    // All-zero reset and initialisation value of one register
    localparam logic [XLEN_DEFAULT-1:0] REG_ZERO = '0;

    // Register address type for the default geometry
    typedef logic [$clog2(NREG_DEFAULT)-1:0] regaddr_t;

endpackage : regfile_sb_pkg
`default_nettype wire

// File: rtl/regfile_sb_score.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_score
// Description : Per-register busy scoreboard with flush > issue > clear
//               priority. Register 0 is hard-wired not busy.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb_score
    import regfile_sb_pkg::*;
#(
    parameter  int NREG = NREG_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            wr_en,
    input  logic            wr_clr,
    input  logic [AW-1:0]   wr_addr,
    input  logic            flush,
    output logic [NREG-1:0] busy_vec
);

    genvar r;
    generate
        for (r = 0; r < NREG; r++) begin : g_busy
            if (r == 0) begin : g_zero
                // x0 never has an outstanding producer
                assign busy_vec[r] = 1'b0;
            end else begin : g_live
                localparam logic [AW-1:0] c_idx = AW'(r);
                logic r_busy;
                logic w_iss_hit;
                logic w_clr_hit;

                assign w_iss_hit = iss_en && (iss_addr == c_idx);
                assign w_clr_hit = wr_en && wr_clr && (wr_addr == c_idx);

                // Busy bit update: flush wins, a new producer beats a same-cycle clear
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_busy <= 1'b0;
                    end else if (flush) begin
                        r_busy <= 1'b0;
                    end else if (w_iss_hit) begin
                        r_busy <= 1'b1;
                    end else if (w_clr_hit) begin
                        r_busy <= 1'b0;
                    end
                end

                assign busy_vec[r] = r_busy;
            end
        end
    endgenerate

endmodule : regfile_sb_score
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised integer register file with write-to-read bypass,
//               RAW busy scoreboard, flush and an unbypassed debug port.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    parameter  int NREG = NREG_DEFAULT,
    parameter  int NRP  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP-1:0]      rd_en,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                wr_clr,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    output logic [NREG-1:0]     busy_vec
);

    localparam logic [XLEN-1:0] c_zero = XLEN'(REG_ZERO);

    // Registered state of every architectural register, x0 reads as zero
    logic [XLEN-1:0] w_regs [NREG];
    // Writeback that also retires the producer of wr_addr
    logic            w_wr_clear;

    assign w_wr_clear = wr_en && wr_clr;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    genvar r;
    generate
        for (r = 0; r < NREG; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign w_regs[r] = c_zero;
            end else begin : g_live
                localparam logic [AW-1:0] c_idx = AW'(r);
                logic [XLEN-1:0] r_q;

                // Writeback capture; reset clears the register
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_q <= c_zero;
                    end else if (wr_en && (wr_addr == c_idx)) begin
                        r_q <= wr_data;
                    end
                end

                assign w_regs[r] = r_q;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    regfile_sb_score #(
        .NREG     (NREG)
    ) u_score (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_clr   (wr_clr),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    // ------------------------------------------------------------------
    // Read ports with write-to-read bypass
    // ------------------------------------------------------------------
    genvar p;
    generate
        for (p = 0; p < NRP; p++) begin : g_rport
            logic [AW-1:0] w_addr;
            logic          w_hit;
            logic          w_clr_hit;

            assign w_addr    = rd_addr[p*AW +: AW];
            // A write to x0 is dropped, so it must never be forwarded
            assign w_hit     = wr_en && (wr_addr == w_addr) && (wr_addr != '0);
            assign w_clr_hit = w_wr_clear && (wr_addr == w_addr);

            assign rd_data[p*XLEN +: XLEN] = !rd_en[p] ? c_zero :
                                             w_hit     ? wr_data :
                                                         w_regs[w_addr];

            // The clearing writeback makes the operand ready in the same cycle
            assign rd_busy[p] = rd_en[p] && busy_vec[w_addr] && !w_clr_hit;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Debug port: pre-edge register state, no bypass
    // ------------------------------------------------------------------
    assign dbg_data = w_regs[dbg_addr];

endmodule : regfile_sb
`default_nettype wire
